mux_nx1_stream: RTL
===================

// Module: mux_nx1_stream
// PURPOSE
//  Parametrised N:1 multiplexer for valid/ready streams with a registered output stage.
//  Two selection modes:
//   - direct select (classic mux: sel picks the channel);
//   - round-robin arbitration among valid channels.
//  Sits between N producer channels and one consumer.
//  Adds handshaking, backpressure, fairness and 1-cycle registered latency over the plain 2:1 mux.
// PARAMETERS
//  WIDTH  8  data bits per channel
//  N      4  number of input channels (N >= 2)
//  SEL_W  localparam = $clog2(N); channel index width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  rr_en      in   1        0 = direct select via sel, 1 = round-robin
//  sel        in   SEL_W    channel index, used only when rr_en=0
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel valid
//  in_ready   out  N        per-channel ready (at most one bit high per cycle)
//  out_data   out  WIDTH    registered output data
//  out_chan   out  SEL_W    index of the channel that produced out_data
//  out_valid  out  1        output register holds a word
//  out_ready  in   1        consumer accepts the word
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0.
//   Applies immediately on rst rise; any held word is discarded.
//  load = ~out_valid | out_ready. The output register accepts a new word only when load=1.
//  Grant, rr_en=0: gnt=sel, gnt_v=in_valid[sel].
//   If sel >= N (N not a power of 2): gnt_v=0.
//  Grant, rr_en=1: gnt = first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   gnt_v = |in_valid.
//  in_ready[i] = load & gnt_v & (gnt==i). It depends combinationally on out_ready.
//  Transfer on input i when in_valid[i] & in_ready[i]. On the next edge:
//   out_data <= channel i data; out_chan <= i; out_valid <= 1.
//  If load=1 and gnt_v=0: out_valid <= 0. out_data and out_chan hold their last values.
//  If out_valid=1 and out_ready=0: out_data, out_chan and out_valid are held stable.
//   All in_ready are 0.
//  Latency: 1 cycle from input transfer to out_valid.
//  Throughput: 1 word/cycle with out_ready held high.
//  ptr updates only on an input transfer while rr_en=1: ptr <= (gnt==N-1) ? 0 : gnt+1.
//   ptr is unchanged in direct mode and when no transfer occurs.
//  Mode or sel change takes effect on the next grant; a word already in the register is unaffected.
//  Fairness: in rr mode, with all channels continuously valid and out_ready=1, each channel is
//   granted exactly once per N consecutive transfers.
//  A channel's valid may drop without a transfer; no state is kept per channel.
// STRUCTURE
//  Package mux_stream_pkg:
//   - MODE_DIRECT=1'b0, MODE_RR=1'b1;
//   - function clog2_safe (returns 1 for N<=2).
//  Sub-module rr_arbiter #(N):
//   - inputs: clk, rst, req[N], advance;
//   - outputs: gnt_idx[SEL_W], gnt_v;
//   - owns ptr and the rotating priority search; advance = transfer & rr_en.
//  Top level: direct/rr grant select, in_ready decode, output register, data slice mux.
// TESTING
//  1 Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_chan=0 in the same cycle.
//    After release, ptr=0 (first rr grant to ch0 when all valid).
//  2 Direct mode, N=4, WIDTH=8, rr_en=0:
//    - sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100;
//    - next cycle out_data=8'hA5, out_chan=2, out_valid=1;
//    - sel=1 with in_valid=4'b0100 -> in_ready=0, out_valid falls next cycle.
//  3 Round-robin, in_valid=4'b1111 held, out_ready=1 for 8 cycles:
//    - out_chan sequence 0,1,2,3,0,1,2,3;
//    - then in_valid=4'b1010 -> 1,3,1,3.
//  4 Backpressure:
//    - word 8'h3C loaded, out_ready=0 for 5 cycles -> out_data=8'h3C held, in_ready=0 throughout;
//    - out_ready=1 with ch1 valid -> same-cycle in_ready[1]=1, next word appears the following cycle.
//  5 Mode switch mid-stream:
//    - rr with ptr=2, switch rr_en=0, sel=0 -> ch0 granted; ptr still 2;
//    - return to rr with all valid -> ch2 granted first.
//  6 N=3 build: rr_en=0, sel=3 with in_valid=3'b111 -> no grant, out_valid=0; rr wraps 0,1,2,0.

Source files
------------

// File: rtl/mux_stream_pkg.sv
// Shared constants and helpers for the N:1 valid/ready stream multiplexer.
package mux_stream_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Channel index width; never collapses to zero bits for tiny N.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr, wrapping around.
module rr_arbiter
    import mux_stream_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = clog2_safe(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_v
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] hi_idx, lo_idx;
    logic             hi_v, lo_v;

    // Requesters at or above ptr outrank those below it; the descending loop leaves the
    // lowest index of each half as the winner.
    always_comb begin
        hi_v   = 1'b0;
        lo_v   = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (SEL_W'(i) >= ptr_q) begin
                    hi_v   = 1'b1;
                    hi_idx = SEL_W'(i);
                end else begin
                    lo_v   = 1'b1;
                    lo_idx = SEL_W'(i);
                end
            end
        end
        gnt_idx = hi_v ? hi_idx : lo_idx;
        gnt_v   = hi_v | lo_v;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready stream mux with direct or round-robin selection and a registered output.
module mux_nx1_stream
    import mux_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SEL_W = clog2_safe(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rr_en,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic             load;
    logic             transfer;
    logic [SEL_W-1:0] gnt, rr_gnt;
    logic             gnt_v, rr_gnt_v, dir_gnt_v;
    logic [WIDTH-1:0] gnt_data;

    assign load = ~out_valid | out_ready;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (transfer & (rr_en == MODE_RR)),
        .gnt_idx (rr_gnt),
        .gnt_v   (rr_gnt_v)
    );

    // sel values at or beyond N (non power-of-two N) match no channel and never grant.
    always_comb begin
        dir_gnt_v = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                dir_gnt_v = in_valid[i];
            end
        end
    end

    assign gnt      = (rr_en == MODE_RR) ? rr_gnt : sel;
    assign gnt_v    = (rr_en == MODE_RR) ? rr_gnt_v : dir_gnt_v;
    assign transfer = load & gnt_v;

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SEL_W'(i)) begin
                in_ready[i] = transfer;
                gnt_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= gnt_v;
            if (gnt_v) begin
                out_data <= gnt_data;
                out_chan <= gnt;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_chan)));

endmodule
